// File: rtl/sh2_bus_arb_pkg.sv
// Shared types for the SH-2 external bus arbiter.
// State encoding, OWNER codes and the default grant timeout.
package SH2_BUS_ARB_PKG;

   typedef enum logic [2:0] {
      MST,
      RELQ,
      SLV,
      EXT,
      HAND,
      RET
   } state_t;

   localparam logic [1:0] OWN_MST = 2'd0;
   localparam logic [1:0] OWN_SLV = 2'd1;
   localparam logic [1:0] OWN_EXT = 2'd2;
   localparam logic [1:0] OWN_TRN = 2'd3;

   localparam int TIMEOUT_DEF = 255;

   function automatic logic [1:0] own_code(state_t s);
      case (s)
         MST:     return OWN_MST;
         SLV:     return OWN_SLV;
         EXT:     return OWN_EXT;
         default: return OWN_TRN;
      endcase
   endfunction

endpackage

// File: rtl/sh2_bus_arb.sv
// Shared SH-2 bus arbiter: master / slave SH7604 and one external requester.
// Define SH2_BUS_ARB_TIMEOUT_EN to abort a stalled master release with ERR.
module sh2_bus_arb
   import SH2_BUS_ARB_PKG::*;
#(
   parameter int FAIR    = 1,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE_R,
   output logic       MSH_BRLS_N,
   input  logic       MSH_BGR_N,
   input  logic       SSH_BREQ_N,
   output logic       SSH_BACK_N,
   input  logic       EXT_REQ,
   output logic       EXT_GNT,
   output logic [1:0] OWNER,
   output logic       ERR
);

   state_t state;
   state_t win;
   logic   last_ext;
   logic   lost;
   logic   s_req;
   logic   e_req;
   logic   go_win;

   assign s_req = ~SSH_BREQ_N;
   assign e_req = EXT_REQ;

   function automatic state_t pick(logic s, logic e, logic lx);
      if (s && e)
         return ((FAIR != 0) && lx) ? SLV : EXT;
      else if (s)
         return SLV;
      else
         return EXT;
   endfunction

   // In HAND the requester not just served goes first, else the same one again.
   always_comb begin
      win = RET;
      if (state == HAND) begin
         if (last_ext)
            win = s_req ? SLV : (e_req ? EXT : RET);
         else
            win = e_req ? EXT : (s_req ? SLV : RET);
      end else begin
         win = pick(s_req, e_req, last_ext);
      end
   end

   assign go_win = ~MSH_BGR_N &
                   (((state == RELQ) & (s_req | e_req)) |
                    ((state == HAND) & ~lost));

`ifdef SH2_BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
`else
   logic unused_cfg;
   assign unused_cfg = ^8'(TIMEOUT);
   assign ERR = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= MST;
         last_ext   <= 1'b0;
         lost       <= 1'b0;
         MSH_BRLS_N <= 1'b1;
         SSH_BACK_N <= 1'b1;
         EXT_GNT    <= 1'b0;
         OWNER      <= OWN_MST;
`ifdef SH2_BUS_ARB_TIMEOUT_EN
         ERR        <= 1'b0;
         cnt        <= 8'd0;
`endif
      end else if (CE_R) begin
`ifdef SH2_BUS_ARB_TIMEOUT_EN
         ERR <= 1'b0;
`endif
         if (go_win) begin
            state      <= win;
            MSH_BRLS_N <= (win == RET);
            SSH_BACK_N <= (win != SLV);
            EXT_GNT    <= (win == EXT);
            OWNER      <= own_code(win);
            if (win != RET)
               last_ext <= (win == EXT);
         end else begin
            unique case (state)
               MST: begin
                  if (s_req | e_req) begin
                     state      <= RELQ;
                     MSH_BRLS_N <= 1'b0;
                     OWNER      <= OWN_TRN;
                     lost       <= 1'b0;
`ifdef SH2_BUS_ARB_TIMEOUT_EN
                     cnt        <= 8'd0;
`endif
                  end
               end
               RELQ: begin
                  if (~(s_req | e_req)) begin
                     state      <= RET;
                     MSH_BRLS_N <= 1'b1;
                  end
`ifdef SH2_BUS_ARB_TIMEOUT_EN
                  else if (cnt == TO_LAST) begin
                     ERR        <= 1'b1;
                     state      <= RET;
                     MSH_BRLS_N <= 1'b1;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
`endif
               end
               SLV: begin
                  if (MSH_BGR_N)
                     lost <= 1'b1;
                  if (SSH_BREQ_N) begin
                     SSH_BACK_N <= 1'b1;
                     OWNER      <= OWN_TRN;
                     if (lost | MSH_BGR_N) begin
                        state      <= RET;
                        MSH_BRLS_N <= 1'b1;
                     end else begin
                        state <= HAND;
                     end
                  end
               end
               EXT: begin
                  if (MSH_BGR_N)
                     lost <= 1'b1;
                  if (~EXT_REQ) begin
                     EXT_GNT <= 1'b0;
                     OWNER   <= OWN_TRN;
                     if (lost | MSH_BGR_N) begin
                        state      <= RET;
                        MSH_BRLS_N <= 1'b1;
                     end else begin
                        state <= HAND;
                     end
                  end
               end
               HAND: begin
                  state      <= RET;
                  MSH_BRLS_N <= 1'b1;
               end
               RET: begin
                  if (MSH_BGR_N) begin
                     state <= MST;
                     OWNER <= OWN_MST;
                  end
               end
               default: state <= MST;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sh2_bus_arb.sv
// Randomized bench for sh2_bus_arb, FAIR=0 and FAIR=1 instances side by side,
// checked every cycle against a flag-level model of the bus ownership rules.
module tb_sh2_bus_arb;

   localparam int TO = 4;

   logic CLK = 1'b0;
   logic RST;
   logic CE_R;
   logic MSH_BGR_N;
   logic SSH_BREQ_N;
   logic EXT_REQ;

   logic       brls_n [2];
   logic       back_n [2];
   logic       gnt    [2];
   logic       err    [2];
   logic [1:0] owner  [2];

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   sh2_bus_arb #(.FAIR(0), .TIMEOUT(TO)) u_f0 (
      .CLK(CLK), .RST(RST), .CE_R(CE_R),
      .MSH_BRLS_N(brls_n[0]), .MSH_BGR_N(MSH_BGR_N),
      .SSH_BREQ_N(SSH_BREQ_N), .SSH_BACK_N(back_n[0]),
      .EXT_REQ(EXT_REQ), .EXT_GNT(gnt[0]),
      .OWNER(owner[0]), .ERR(err[0])
   );

   sh2_bus_arb #(.FAIR(1), .TIMEOUT(TO)) u_f1 (
      .CLK(CLK), .RST(RST), .CE_R(CE_R),
      .MSH_BRLS_N(brls_n[1]), .MSH_BGR_N(MSH_BGR_N),
      .SSH_BREQ_N(SSH_BREQ_N), .SSH_BACK_N(back_n[1]),
      .EXT_REQ(EXT_REQ), .EXT_GNT(gnt[1]),
      .OWNER(owner[1]), .ERR(err[1])
   );

   // Model: who holds the bus (0 none, 1 slave, 2 ext) plus phase flags.
   bit m_rel  [2];
   bit m_ret  [2];
   bit m_gap  [2];
   bit m_lost [2];
   bit m_lx   [2];
   bit m_err  [2];
   int m_hold [2];
   int m_cnt  [2];

   function automatic int exp_owner(int k);
      if (m_hold[k] == 1) return 1;
      if (m_hold[k] == 2) return 2;
      if (m_ret[k] || m_gap[k] || m_rel[k]) return 3;
      return 0;
   endfunction

   task automatic leave(int k);
      m_rel[k] = 0;
      m_ret[k] = 1;
   endtask

   task automatic serve(int k, int who);
      m_hold[k] = who;
      m_lx[k] = (who == 2);
   endtask

   task automatic model_step();
      bit s, e, lx;
      s = !SSH_BREQ_N;
      e = EXT_REQ;
      for (int k = 0; k < 2; k++) begin
         if (RST) begin
            m_rel[k] = 0; m_ret[k] = 0; m_gap[k] = 0; m_lost[k] = 0;
            m_lx[k] = 0; m_err[k] = 0; m_hold[k] = 0; m_cnt[k] = 0;
         end else if (CE_R) begin
            m_err[k] = 0;
            if (m_ret[k]) begin
               if (MSH_BGR_N) m_ret[k] = 0;
            end else if (!m_rel[k]) begin
               if (s || e) begin
                  m_rel[k] = 1; m_cnt[k] = 0; m_lost[k] = 0;
               end
            end else if (m_hold[k] != 0) begin
               if (MSH_BGR_N) m_lost[k] = 1;
               if ((m_hold[k] == 1 && !s) || (m_hold[k] == 2 && !e)) begin
                  if (m_lost[k]) leave(k);
                  else m_gap[k] = 1;
                  m_hold[k] = 0;
               end
            end else if (m_gap[k]) begin
               m_gap[k] = 0;
               lx = m_lx[k];
               if (MSH_BGR_N || m_lost[k]) leave(k);
               else if (lx ? s : e) serve(k, lx ? 1 : 2);
               else if (lx ? e : s) serve(k, lx ? 2 : 1);
               else leave(k);
            end else begin
               if (!(s || e)) leave(k);
               else if (!MSH_BGR_N) begin
                  if (s && e) serve(k, (k == 1 && m_lx[k]) ? 1 : 2);
                  else serve(k, s ? 1 : 2);
               end
`ifdef SH2_BUS_ARB_TIMEOUT_EN
               else begin
                  m_cnt[k]++;
                  if (m_cnt[k] == TO) begin
                     m_err[k] = 1;
                     leave(k);
                  end
               end
`endif
            end
         end
      end
   endtask

   task automatic cmp(string nm, int k, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s f%0d: got %0d want %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         cmp("brls_n", k, int'(brls_n[k]), int'(!m_rel[k]));
         cmp("back_n", k, int'(back_n[k]), int'(m_hold[k] != 1));
         cmp("gnt", k, int'(gnt[k]), int'(m_hold[k] == 2));
         cmp("owner", k, int'(owner[k]), exp_owner(k));
         cmp("err", k, int'(err[k]), int'(m_err[k]));
      end
   endtask

   task automatic tick(bit ce, bit rst, bit bgr_n, bit breq_n, bit ext);
      CE_R = ce;
      RST = rst;
      MSH_BGR_N = bgr_n;
      SSH_BREQ_N = breq_n;
      EXT_REQ = ext;
      model_step();
      @(negedge CLK);
      check_model();
   endtask

   bit ce, rs, bg, bq, ex;

   initial begin
      RST = 1; CE_R = 1; MSH_BGR_N = 1; SSH_BREQ_N = 1; EXT_REQ = 0;
      @(negedge CLK);

      // slave only
      tick(1, 1, 1, 1, 0);
      cmp("rst_owner", 1, int'(owner[1]), 0);
      cmp("rst_brls", 1, int'(brls_n[1]), 1);
      cmp("rst_back", 1, int'(back_n[1]), 1);
      cmp("rst_gnt", 1, int'(gnt[1]), 0);
      cmp("rst_err", 1, int'(err[1]), 0);
      tick(1, 0, 1, 0, 0);
      cmp("s1_brls_lo", 1, int'(brls_n[1]), 0);
      tick(1, 0, 1, 0, 0);
      cmp("s1_no_back", 1, int'(back_n[1]), 1);
      tick(1, 0, 0, 0, 0);
      cmp("s1_back", 1, int'(back_n[1]), 0);
      cmp("s1_owner", 1, int'(owner[1]), 1);
      tick(0, 0, 0, 1, 0);
      cmp("ce_hold", 1, int'(back_n[1]), 0);
      tick(1, 0, 0, 1, 0);
      cmp("s1_hand_back", 1, int'(back_n[1]), 1);
      cmp("s1_hand_own", 1, int'(owner[1]), 3);
      cmp("s1_hand_brls", 1, int'(brls_n[1]), 0);
      tick(1, 0, 0, 1, 0);
      cmp("s1_ret_brls", 1, int'(brls_n[1]), 1);
      tick(1, 0, 1, 1, 0);
      cmp("s1_mst", 1, int'(owner[1]), 0);

      // simultaneous requests
      tick(1, 1, 1, 1, 0);
      tick(1, 0, 1, 0, 1);
      tick(1, 0, 0, 0, 1);
      cmp("s2_gnt", 1, int'(gnt[1]), 1);
      cmp("s2_owner", 1, int'(owner[1]), 2);
      cmp("s2_back", 1, int'(back_n[1]), 1);
      cmp("s2_gnt", 0, int'(gnt[0]), 1);
      tick(1, 0, 0, 0, 0);
      cmp("s2_hand_gnt", 1, int'(gnt[1]), 0);
      cmp("s2_hand_own", 1, int'(owner[1]), 3);
      cmp("s2_hand_brls", 1, int'(brls_n[1]), 0);
      tick(1, 0, 0, 0, 0);
      cmp("s2_slv_back", 1, int'(back_n[1]), 0);
      cmp("s2_slv_brls", 1, int'(brls_n[1]), 0);
      tick(1, 0, 0, 1, 0);
      tick(1, 0, 0, 1, 0);
      tick(1, 0, 1, 1, 0);

      // FAIR=0 back-to-back
      tick(1, 1, 1, 1, 0);
      tick(1, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 1);
      cmp("s3_back", 0, int'(back_n[0]), 0);
      cmp("s3_gnt", 0, int'(gnt[0]), 0);
      tick(1, 0, 0, 1, 1);
      cmp("s3_hand", 0, int'(owner[0]), 3);
      tick(1, 0, 0, 0, 1);
      cmp("s3_ext_gnt", 0, int'(gnt[0]), 1);
      cmp("s3_ext_back", 0, int'(back_n[0]), 1);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      cmp("s3_slv_again", 0, int'(back_n[0]), 0);
      tick(1, 0, 0, 1, 0);
      tick(1, 0, 0, 1, 0);
      tick(1, 0, 1, 1, 0);

      // request withdrawn in RELQ
      tick(1, 1, 1, 1, 0);
      tick(1, 0, 1, 1, 1);
      tick(1, 0, 0, 1, 0);
      cmp("s4_gnt", 1, int'(gnt[1]), 0);
      cmp("s4_brls", 1, int'(brls_n[1]), 1);
      cmp("s4_own", 1, int'(owner[1]), 3);
      tick(1, 0, 0, 1, 0);
      cmp("s4_ret_wait", 1, int'(owner[1]), 3);
      tick(1, 0, 1, 1, 0);
      cmp("s4_mst", 1, int'(owner[1]), 0);

      // master drops its grant during SLV
      tick(1, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 1, 0, 0);
      cmp("s5_keep", 1, int'(back_n[1]), 0);
      tick(1, 0, 1, 1, 0);
      cmp("s5_ret_brls", 1, int'(brls_n[1]), 1);
      cmp("s5_ret_back", 1, int'(back_n[1]), 1);
      tick(1, 0, 1, 1, 0);
      cmp("s5_mst", 1, int'(owner[1]), 0);

      // reset during SLV
      tick(1, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      cmp("s6_back", 1, int'(back_n[1]), 1);
      cmp("s6_brls", 1, int'(brls_n[1]), 1);
      cmp("s6_owner", 1, int'(owner[1]), 0);

`ifdef SH2_BUS_ARB_TIMEOUT_EN
      tick(1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 1, 0, 0);
         cmp("to_early", 1, int'(err[1]), 0);
      end
      tick(1, 0, 1, 0, 0);
      cmp("to_err", 1, int'(err[1]), 1);
      cmp("to_brls", 1, int'(brls_n[1]), 1);
      tick(1, 0, 1, 0, 0);
      cmp("to_pulse", 1, int'(err[1]), 0);
      cmp("to_mst", 1, int'(owner[1]), 0);
`endif

      // random traffic
      tick(1, 1, 1, 1, 0);
      for (int i = 0; i < 4000; i++) begin
         ce = ($urandom_range(0, 4) != 0);
         rs = ($urandom_range(0, 299) == 0);
         bg = MSH_BGR_N;
         if ($urandom_range(0, 1) == 1) bg = !m_rel[1];
         if ($urandom_range(0, 49) == 0) bg = !bg;
         if (SSH_BREQ_N) bq = ($urandom_range(0, 5) != 0);
         else bq = ($urandom_range(0, 4) == 0);
         if (!EXT_REQ) ex = ($urandom_range(0, 5) == 0);
         else ex = ($urandom_range(0, 4) != 0);
         tick(ce, rs, bg, bq, ex);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
